sa_input_skew_feeder: RTL

SA_INPUT_SKEW_FEEDER -- requirements
Module: sa_input_skew_feeder

---
 rtl/sa_input_skew_feeder_if.sv | 14 +
 rtl/sa_input_skew_feeder.sv | 77 +++++++
 2 files changed

// File: rtl/sa_input_skew_feeder_if.sv
// sa_input_skew_feeder_if: tile row handshake plus skewed feature streams toward the array
interface sa_input_skew_feeder_if #(parameter int DATA_WIDTH = 16);
  logic [4*DATA_WIDTH-1:0] in_data;
  logic in_valid;
  logic in_ready;
  logic [DATA_WIDTH-1:0] fd0;
  logic [DATA_WIDTH-1:0] fd4;
  logic [DATA_WIDTH-1:0] fd8;
  logic [DATA_WIDTH-1:0] fd12;
  logic result_ld;
  logic busy;
  modport master (output in_data, in_valid, input in_ready, fd0, fd4, fd8, fd12, result_ld, busy);
  modport slave (input in_data, in_valid, output in_ready, fd0, fd4, fd8, fd12, result_ld, busy);
endinterface

// File: rtl/sa_input_skew_feeder.sv
// sa_input_skew_feeder: buffers a 4x4 tile and feeds it diagonally skewed into a systolic array
module sa_input_skew_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int DRAIN_CYCLES = 4
) (
  input logic clk,
  input logic rst,
  sa_input_skew_feeder_if.slave s
);
  typedef enum logic [1:0] {LOAD, STREAM, DRAIN, DONE} state_t;
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);
  state_t state, state_nx;
  logic [1:0] lc, lc_nx;
  logic [3:0] st, st_nx;
  logic [4*DATA_WIDTH-1:0] tile_buf [4];
  logic [DATA_WIDTH-1:0] fd [4];
  logic [DATA_WIDTH-1:0] fd_nx [4];
  logic accept;
  assign accept = state == LOAD && s.in_valid;
  // state and counter registers; an asynchronous reset aborts any tile in flight
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= LOAD;
      lc <= 2'd0;
      st <= 4'd0;
    end else begin
      state <= state_nx;
      lc <= lc_nx;
      st <= st_nx;
    end
  // sequencing: four accepts, seven skew steps, drain, one result-load cycle
  always_comb begin
    state_nx = state;
    lc_nx = lc;
    st_nx = st;
    case (state)
      LOAD: if (s.in_valid) begin
        lc_nx = lc + 2'd1;
        state_nx = lc == 2'd3 ? STREAM : LOAD;
        st_nx = 4'd0;
      end
      STREAM: begin
        state_nx = st == 4'd6 ? DRAIN : STREAM;
        st_nx = st == 4'd6 ? 4'd0 : st + 4'd1;
      end
      DRAIN: begin
        state_nx = st == DRAIN_LAST ? DONE : DRAIN;
        st_nx = st == DRAIN_LAST ? 4'd0 : st + 4'd1;
      end
      default: begin
        state_nx = LOAD;
        st_nx = 4'd0;
      end
    endcase
  end
  // tile buffer written only while loading, so it stays frozen through the stream
  always_ff @(posedge clk or negedge rst)
    if (!rst) tile_buf <= '{default: '0};
    else if (accept) tile_buf[lc] <= s.in_data;
  // lane i shows row (t - i) at step t; computed from the next step so the value lands with st
  always_comb begin
    for (int i = 0; i < 4; i++)
      fd_nx[i] = state_nx == STREAM && st_nx >= 4'(i) && st_nx - 4'(i) <= 4'd3 ?
                 tile_buf[2'(st_nx - 4'(i))][i*DATA_WIDTH +: DATA_WIDTH] : '0;
  end
  // registered feature outputs; step 0 never needs the row being written on the last accept
  always_ff @(posedge clk or negedge rst)
    if (!rst) fd <= '{default: '0};
    else fd <= fd_nx;
  assign s.fd0 = fd[0];
  assign s.fd4 = fd[1];
  assign s.fd8 = fd[2];
  assign s.fd12 = fd[3];
  assign s.in_ready = state == LOAD;
  assign s.busy = state != LOAD;
  assign s.result_ld = state == DONE;
endmodule
